button_debounce: RTL and testbench

- Conditions one raw push-button input before it reaches the Avalon PIO input port (in_port) of the button PIO slave.
- Synchronises the asynchronous pin into clk and removes contact bounce with a counter-qualified FSM.
- Produces a clean active-high pressed level for the PIO, plus single-cycle press/release/long-press strobes and a wrapping press counter for other fabric logic.

---
 rtl/button_debounce.sv | 147 ++++++++++++++
 tb/tb_button_debounce.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser plus counter-qualified
// debounce FSM with press/release/long-press strobes and a press counter.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int CNT_W           = 26,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_raw,
  output logic       level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    S_REL,
    S_PCHK,
    S_PRS,
    S_RCHK
  } state_t;

  localparam logic REL_PIN = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_dcnt;
  logic [CNT_W-1:0] r_hold;
  logic             r_fired;
  logic             r_level;
  logic             r_press;
  logic             r_rel;
  logic             r_long;
  logic [7:0]       r_cnt;

  logic             w_p;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_dcnt_nxt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic             w_fired_nxt;
  logic             w_level_nxt;
  logic             w_press_nxt;
  logic             w_rel_nxt;
  logic             w_long_nxt;
  logic [7:0]       w_cnt_nxt;

  // p is 1 when the synchronised pin reads pressed
  assign w_p = r_s2 ^ REL_PIN;

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_hold_nxt  = r_hold;
    w_fired_nxt = r_fired;
    w_level_nxt = r_level;
    w_press_nxt = 1'b0;
    w_rel_nxt   = 1'b0;
    w_long_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_REL: begin
        if (w_p) begin
          w_state_nxt = S_PCHK;
          w_dcnt_nxt  = '0;
        end
      end
      S_PCHK: begin
        if (!w_p) begin
          w_state_nxt = S_REL;
        end else if (r_dcnt == DB_LAST) begin
          w_state_nxt = S_PRS;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + 8'd1;
          w_hold_nxt  = '0;
          w_fired_nxt = 1'b0;
        end else begin
          w_dcnt_nxt = r_dcnt + CNT_W'(1);
        end
      end
      S_PRS: begin
        if (!w_p) begin
          w_state_nxt = S_RCHK;
          w_dcnt_nxt  = '0;
        end else if (!r_fired && r_hold == LG_LAST) begin
          w_long_nxt  = 1'b1;
          w_fired_nxt = 1'b1;
        end else if (!r_fired) begin
          w_hold_nxt = r_hold + CNT_W'(1);
        end
      end
      S_RCHK: begin
        if (w_p) begin
          w_state_nxt = S_PRS;
        end else if (r_dcnt == DB_LAST) begin
          w_state_nxt = S_REL;
          w_level_nxt = 1'b0;
          w_rel_nxt   = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_REL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= REL_PIN;
      r_s2    <= REL_PIN;
      r_state <= S_REL;
      r_dcnt  <= '0;
      r_hold  <= '0;
      r_fired <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
      r_long  <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_s1    <= button_raw;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_hold  <= w_hold_nxt;
      r_fired <= w_fired_nxt;
      r_level <= w_level_nxt;
      r_press <= w_press_nxt;
      r_rel   <= w_rel_nxt;
      r_long  <= w_long_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign level         = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_rel;
  assign long_pulse    = r_long;
  assign press_count   = r_cnt;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: run-length reference model compared every
// cycle, plus directed scenarios with literal edge-count expectations.
module tb_button_debounce;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int AL   = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       button_raw;
  logic       level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int tests = 0;
  int fails = 0;

  button_debounce #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LONG),
    .CNT_W(8),
    .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_raw(button_raw),
    .level(level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a change is accepted once the synchronised pin has
  // disagreed with the debounced level for DB+1 consecutive edges.
  logic m_valid = 1'b0;
  logic h1, h2, m_p, prev_p;
  logic m_level, m_press, m_rel, m_long, fired;
  int   run, t, m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      h1 = 1'b1; h2 = 1'b1; prev_p = 1'b0;
      m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
      fired = 0; run = 0; t = 0; m_cnt = 0;
      m_valid = 1'b1;
    end else begin
      m_p = h2 ^ AL[0];
      h2 = h1;
      h1 = button_raw;
      m_press = 0; m_rel = 0; m_long = 0;
      if (m_p != m_level) begin
        run++;
        if (run == DB + 1) begin
          run = 0;
          if (m_p) begin
            m_level = 1; m_press = 1;
            m_cnt = (m_cnt + 1) % 256;
            t = 0; fired = 0;
          end else begin
            m_level = 0; m_rel = 1;
          end
        end
      end else begin
        run = 0;
        if (m_level && m_p && prev_p && !fired) begin
          t++;
          if (t == LONG) begin
            m_long = 1; fired = 1;
          end
        end
      end
      prev_p = m_p;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_level", int'(level), int'(m_level));
      check("cmp_press", int'(press_pulse), int'(m_press));
      check("cmp_release", int'(release_pulse), int'(m_rel));
      check("cmp_long", int'(long_pulse), int'(m_long));
      check("cmp_count", int'(press_count), m_cnt);
    end
  end

  int n, pos, any;

  initial begin
    reset = 1'b1;
    button_raw = 1'b1;
    step(3);
    check("rst_level", int'(level), 0);
    check("rst_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
    check("rst_count", int'(press_count), 0);
    reset = 1'b0;
    any = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      any |= int'({level, press_pulse, release_pulse, long_pulse});
    end
    check("idle_quiet", any, 0);
    check("idle_count", int'(press_count), 0);

    // clean press: accepted after edge 7
    button_raw = 1'b0;
    step(6);
    check("press_e6_level", int'(level), 0);
    check("press_e6_pulse", int'(press_pulse), 0);
    step(1);
    check("press_e7_level", int'(level), 1);
    check("press_e7_pulse", int'(press_pulse), 1);
    step(1);
    check("press_e8_pulse", int'(press_pulse), 0);
    check("press_e8_count", int'(press_count), 1);
    button_raw = 1'b1;
    step(10);
    check("rel_level", int'(level), 0);

    // glitch of 3 cycles is rejected
    button_raw = 1'b0;
    step(3);
    button_raw = 1'b1;
    any = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      any |= int'({level, press_pulse, release_pulse, long_pulse});
    end
    check("glitch_quiet", any, 0);
    check("glitch_count", int'(press_count), 1);

    // long press fires once, 20 cycles after press_pulse
    button_raw = 1'b0;
    step(7);
    check("long_press_pulse", int'(press_pulse), 1);
    n = 0; pos = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (long_pulse) begin
        n++;
        pos = i;
      end
    end
    check("long_once", n, 1);
    check("long_pos", pos, 20);

    // release with bounce: level holds, release after 7 edges
    button_raw = 1'b1;
    step(2);
    button_raw = 1'b0;
    step(1);
    button_raw = 1'b1;
    n = 0; pos = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (i < 7) check("bounce_level", int'(level), 1);
      if (release_pulse) begin
        n++;
        pos = i;
      end
    end
    check("bounce_rel_once", n, 1);
    check("bounce_rel_pos", pos, 7);
    check("bounce_level_end", int'(level), 0);

    // counter wrap after 256 presses
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);
    check("wrap_start", int'(press_count), 0);
    for (int k = 1; k <= 256; k++) begin
      button_raw = 1'b0;
      step(8);
      button_raw = 1'b1;
      step(8);
      if (k == 255) check("wrap_255", int'(press_count), 255);
    end
    check("wrap_zero", int'(press_count), 0);

    // reset during PRESS_CHK with pin held pressed
    button_raw = 1'b0;
    step(8);
    button_raw = 1'b1;
    step(8);
    check("pre_rst_count", int'(press_count), 1);
    button_raw = 1'b0;
    step(4);
    reset = 1'b1;
    step(1);
    check("midrst_count", int'(press_count), 0);
    check("midrst_level", int'(level), 0);
    check("midrst_pulses",
          int'({press_pulse, release_pulse, long_pulse}), 0);
    step(1);
    reset = 1'b0;
    n = 0; pos = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (press_pulse) begin
        n++;
        pos = i;
      end
    end
    check("postrst_press_once", n, 1);
    check("postrst_press_pos", pos, 7);
    check("postrst_count", int'(press_count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
